mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
Iterative multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the rs_data/rt_data operand pair for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers. It runs one radix-2 step per cycle, stalls issue via busy, and pulses done when HI/LO are updated.

Parameters:
BUS_W, 32, operand/HI/LO width; must be even and >= 4.
CNT_W, $clog2(BUS_W+1), iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  issue request; sampled only in IDLE.
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU; 6-7 reserved (ignored).
rs_data  input  BUS_W  multiplicand / dividend.
rt_data  input  BUS_W  multiplier / divisor.
hi_we  input  1  MTHI write.
lo_we  input  1  MTLO write.
mt_data  input  BUS_W  MTHI/MTLO data.
busy  output  1  high from the edge after start is accepted until done.
done  output  1  one-cycle pulse; HI/LO are valid this cycle.
div_zero  output  1  pulses with done when a DIV/DIVU divisor was 0.
hi  output  BUS_W  HI register.
lo  output  BUS_W  LO register.

Behaviour:
- All outputs are registered. Reset (sync, rst=1 at an edge) sets state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and counter=0.
- FSM states:
  - IDLE: start & valid op -> CALC. Operands are latched, magnitudes are taken for signed ops, result signs are recorded, and counter=0.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per edge, counter++. When counter==BUS_W-1 -> FINISH.
  - FINISH: sign fix-up, HI/LO written, done=1 and busy=0 for the following cycle -> IDLE.
- Latency: start sampled at edge k; hi/lo update and done rises at edge k+BUS_W+1 (33 for BUS_W=32). busy is high from edge k+1 to edge k+BUS_W+1.
- Multiply result: {hi,lo} = full 2*BUS_W product. Signed ops use two's-complement.
- Divide result: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
- Signed overflow: DIV of most-negative by -1 gives lo=most-negative, hi=0, no flag.
- Divide by zero: still takes full latency. Result lo = all ones, hi = rs_data, div_zero=1 with done.
- start while busy is ignored; no queueing.
- hi_we/lo_we while busy or in the same cycle as an accepted start are ignored.
- hi_we/lo_we in IDLE write the respective register at the next edge. hi_we and lo_we may both be set; both registers then take mt_data.
- done and a new start in the same cycle: start is accepted, since state is IDLE during the done cycle.
- Reset mid-operation aborts the operation: no done, HI/LO are cleared.
- Reserved op codes with start=1 are ignored and the unit stays IDLE.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: MADD/MADDU produce {hi,lo} <= {hi,lo} + product, mod 2^(2*BUS_W). The accumulation uses the HI/LO values at the FINISH edge and is done in an extra adder in FINISH; latency is unchanged.
- Not defined: op 4/5 behave exactly as MULT/MULTU, overwriting HI/LO with no accumulate.

Decomposition:
- Package mdu_pkg:
  - mdu_op_e enum (3 bits, encodings above).
  - mdu_state_e enum (IDLE, CALC, FINISH).
  - Helper function is_signed(op) and is_div(op).
- One sub-module, mdu_div_step: combinational restoring-divide step. Inputs are the partial remainder and divisor; outputs are the next remainder and quotient bit.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 33 edges: hi=0xFFFFFFFE, lo=0x00000001, done for 1 cycle, busy low the same cycle.
2. MULT rs=0xFFFFFFFD (-3) rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=2 -> lo=3, hi=1. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 with done. Next op: div_zero=0.
5. Mid-operation stimulus:
   - Second start during busy: ignored; only one done.
   - hi_we during busy: hi unchanged.
   - rst at CALC cycle 10: next cycle busy=0, hi=lo=0, and no done for 40 cycles.
6. MTLO 5, MTHI 0, then MADD rs=2 rt=3 -> with MDU_MADD_EN lo=11, hi=0; without it lo=6, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } mdu_state_e;

    // Ops that treat operands as two's-complement.
    function automatic logic is_signed(input mdu_op_e op);
        case (op)
            OP_MULT, OP_DIV, OP_MADD: is_signed = 1'b1;
            default:                  is_signed = 1'b0;
        endcase
    endfunction

    // Ops that run the restoring-divide datapath.
    function automatic logic is_div(input mdu_op_e op);
        case (op)
            OP_DIV, OP_DIVU: is_div = 1'b1;
            default:         is_div = 1'b0;
        endcase
    endfunction

    // Ops that accumulate into HI/LO when accumulation is built in.
    function automatic logic is_madd(input mdu_op_e op);
        case (op)
            OP_MADD, OP_MADDU: is_madd = 1'b1;
            default:           is_madd = 1'b0;
        endcase
    endfunction

    // Reserved encodings are not issued.
    function automatic logic is_valid(input mdu_op_e op);
        case (op)
            OP_RSV6, OP_RSV7: is_valid = 1'b0;
            default:          is_valid = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step: trial-subtract the divisor from the
// shifted partial remainder and keep the difference when it does not go negative.
module mdu_div_step #(
    parameter int BUS_W = 32
) (
    input  logic [BUS_W:0]   part_rem,
    input  logic [BUS_W-1:0] divisor,
    output logic [BUS_W-1:0] next_rem,
    output logic             q_bit
);

    logic [BUS_W:0] diff_s;

    // The partial remainder is always below twice the divisor, so BUS_W+1 bits
    // are enough for the sign of the trial difference to be meaningful.
    assign diff_s   = part_rem - {1'b0, divisor};
    assign q_bit    = ~diff_s[BUS_W];
    assign next_rem = q_bit ? diff_s[BUS_W-1:0] : part_rem[BUS_W-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
// Optional accumulate for MADD/MADDU is built when MDU_MADD_EN is defined;
// otherwise those ops behave as MULT/MULTU.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [BUS_W-1:0] rs_data,
    input  logic [BUS_W-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [BUS_W-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [BUS_W-1:0] hi,
    output logic [BUS_W-1:0] lo
);

    localparam int CNT_W = $clog2(BUS_W + 1);

    mdu_state_e       state_r, next_state_s;
    mdu_op_e          op_s, op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [BUS_W-1:0] opb_r, rs_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
    logic             neg_a_r, neg_rem_r, dz_r;
    logic             busy_r, done_r, div_zero_r;

    logic             accept_s;
    logic [BUS_W-1:0] rs_mag_s, rt_mag_s;
    logic [BUS_W:0]   add_s;
    logic [BUS_W:0]   part_rem_s;
    logic [BUS_W-1:0] next_rem_s;
    logic             q_bit_s;
    logic [2*BUS_W-1:0] prod_fix_s;
    logic [BUS_W-1:0] res_hi_s, res_lo_s;

    assign op_s     = mdu_op_e'(op);
    assign accept_s = (state_r == ST_IDLE) && start && is_valid(op_s);
    assign rs_mag_s = (is_signed(op_s) && rs_data[BUS_W-1]) ? -rs_data : rs_data;
    assign rt_mag_s = (is_signed(op_s) && rt_data[BUS_W-1]) ? -rt_data : rt_data;

    // Multiply step: conditionally add the multiplicand, then shift the pair right.
    assign add_s      = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {(BUS_W+1){1'b0}});
    // Divide step: bring the next dividend bit into the partial remainder.
    assign part_rem_s = {acc_hi_r, acc_lo_r[BUS_W-1]};

    mdu_div_step #(.BUS_W(BUS_W)) u_div_step (
        .part_rem (part_rem_s),
        .divisor  (opb_r),
        .next_rem (next_rem_s),
        .q_bit    (q_bit_s)
    );

    assign prod_fix_s = neg_a_r ? -{acc_hi_r, acc_lo_r} : {acc_hi_r, acc_lo_r};

    // Final sign fix-up and divide-by-zero / accumulate result selection.
    always_comb begin
        res_hi_s = prod_fix_s[2*BUS_W-1:BUS_W];
        res_lo_s = prod_fix_s[BUS_W-1:0];
        if (is_div(op_r)) begin
            if (dz_r) begin
                res_hi_s = rs_r;
                res_lo_s = {BUS_W{1'b1}};
            end else begin
                res_hi_s = neg_rem_r ? -acc_hi_r : acc_hi_r;
                res_lo_s = neg_a_r ? -acc_lo_r : acc_lo_r;
            end
        end else begin
`ifdef MDU_MADD_EN
            if (is_madd(op_r)) begin
                {res_hi_s, res_lo_s} = {hi_r, lo_r} + prod_fix_s;
            end else begin
                {res_hi_s, res_lo_s} = prod_fix_s;
            end
`else
            {res_hi_s, res_lo_s} = prod_fix_s;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = ST_CALC;
                else          next_state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (cnt_r == CNT_W'(BUS_W - 1)) next_state_s = ST_FINISH;
                else                            next_state_s = ST_CALC;
            end
            ST_FINISH: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= next_state_s;
    end

    // Datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= OP_MULT;
            cnt_r      <= {CNT_W{1'b0}};
            opb_r      <= {BUS_W{1'b0}};
            rs_r       <= {BUS_W{1'b0}};
            acc_hi_r   <= {BUS_W{1'b0}};
            acc_lo_r   <= {BUS_W{1'b0}};
            hi_r       <= {BUS_W{1'b0}};
            lo_r       <= {BUS_W{1'b0}};
            neg_a_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            dz_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r      <= op_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        rs_r      <= rs_data;
                        acc_hi_r  <= {BUS_W{1'b0}};
                        acc_lo_r  <= is_div(op_s) ? rs_mag_s : rt_mag_s;
                        opb_r     <= is_div(op_s) ? rt_mag_s : rs_mag_s;
                        neg_a_r   <= is_signed(op_s) && (rs_data[BUS_W-1] ^ rt_data[BUS_W-1]);
                        neg_rem_r <= is_signed(op_s) && rs_data[BUS_W-1];
                        dz_r      <= is_div(op_s) && (rt_data == {BUS_W{1'b0}});
                        busy_r    <= 1'b1;
                    end else begin
                        if (hi_we) hi_r <= mt_data;
                        if (lo_we) lo_r <= mt_data;
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (is_div(op_r)) begin
                        acc_hi_r <= next_rem_s;
                        acc_lo_r <= {acc_lo_r[BUS_W-2:0], q_bit_s};
                    end else begin
                        acc_hi_r <= add_s[BUS_W:1];
                        acc_lo_r <= {add_s[0], acc_lo_r[BUS_W-1:1]};
                    end
                end
                ST_FINISH: begin
                    hi_r       <= res_hi_s;
                    lo_r       <= res_lo_s;
                    done_r     <= 1'b1;
                    div_zero_r <= dz_r;
                    busy_r     <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: stimulus pushes expected HI/LO results,
// a monitor pops and compares on every done pulse.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, mt_data;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;
    exp_t exp_q[$];

    mdu_iterative #(.BUS_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done actual hi=%h lo=%h required no done", hi, lo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL result actual hi=%h lo=%h dz=%b busy=%b required hi=%h lo=%h dz=%b busy=0",
                             hi, lo, div_zero, busy, e.hi, e.lo, e.dz);
                end
            end
        end
    end

    // Called at a negedge: issues start for one cycle, returns at the next negedge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; returns number of negedges waited (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no done required done within 60 cycles");
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz);
        int lat;
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = edz;
        exp_q.push_back(e);
        start_op(o, a, b);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(lat);
        check({name, "_latency"}, lat, 32'd33);
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        hi_we = h; lo_we = l; mt_data = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  seen;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 3'd0; rs_data = 32'd0; rt_data = 32'd0; mt_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz",   {31'd0, div_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back ops: each start lands in the done cycle of the previous one.
        do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        do_op("mult_nn",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
        do_op("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op("div_negd",  3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op("divu",      3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0);
        do_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        do_op("div_zero",  3'd2, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1);
        do_op("divu_after",3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);

        // Reserved op is ignored.
        start_op(3'd6, 32'd1, 32'd1);
        check("rsvd_busy", {31'd0, busy}, 32'd0);

        // MTHI in idle, then start + hi_we during busy are both ignored.
        mt_write(1'b1, 1'b0, 32'hA5A5A5A5);
        check("mthi", hi, 32'hA5A5A5A5);
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd6; e.dz = 1'b0;
            exp_q.push_back(e);
        end
        start_op(3'd1, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        hi_we = 1'b1; mt_data = 32'h11111111;
        start_op(3'd1, 32'd9, 32'd9);
        hi_we = 1'b0;
        check("hi_we_busy", hi, 32'hA5A5A5A5);
        check("busy_mid", {31'd0, busy}, 32'd1);
        wait_done(lat);
        repeat (40) @(negedge clk);

        // Reset around CALC cycle 10 aborts the op.
        start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);

        // MTLO/MTHI then MADD.
        mt_write(1'b0, 1'b1, 32'd5);
        check("mtlo", lo, 32'd5);
        mt_write(1'b1, 1'b0, 32'd0);
        check("mthi0", hi, 32'd0);
`ifdef MDU_MADD_EN
        do_op("madd", 3'd4, 32'd2, 32'd3, 32'd0, 32'd11, 1'b0);
`else
        do_op("madd", 3'd4, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
`endif

        // Both write enables at once load both registers.
        mt_write(1'b1, 1'b1, 32'hCAFEF00D);
        check("mt_both_hi", hi, 32'hCAFEF00D);
        check("mt_both_lo", lo, 32'hCAFEF00D);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
